// File: rtl/logic_gate_pipe_if.sv
// Operand/result handshake bundle for the bit-ops lane.
// slave = the gate pipe, master = the operand source and result consumer.
interface logic_gate_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       y_op;
  logic             y_zero;
  logic [CNT_W-1:0] res_cnt;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_op, y_zero, res_cnt
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_op, y_zero, res_cnt
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage bitwise gate pipeline (NOT/BUF/AND/OR/XOR/NAND/NOR/XNOR) with
// valid/ready on both sides and a wrapping completed-result counter.
module logic_gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_BUF  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XNOR = 3'b111
  } gate_op_e;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] y_q;
  logic [2:0]       y_op_q;
  logic             y_zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_free_c;
  logic             s1_adv_c;
  logic             in_hs_c;
  logic             out_hs_c;
  logic [WIDTH-1:0] gate_c;

  // Handshake and advance decisions; in_ready is the only comb output path.
  assign s2_free_c = !s2_valid_q || bus.out_ready;
  assign s1_adv_c  = s1_valid_q && s2_free_c;
  assign in_hs_c   = bus.in_valid && bus.in_ready;
  assign out_hs_c  = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = !s1_valid_q || s2_free_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.y         = y_q;
  assign bus.y_op      = y_op_q;
  assign bus.y_zero    = y_zero_q;
  assign bus.res_cnt   = cnt_q;

  always_comb begin
    gate_c = '0;
    unique case (gate_op_e'(s1_op_q))
      OP_NOT:  gate_c = ~s1_a_q;
      OP_BUF:  gate_c = s1_a_q;
      OP_AND:  gate_c = s1_a_q & s1_b_q;
      OP_OR:   gate_c = s1_a_q | s1_b_q;
      OP_XOR:  gate_c = s1_a_q ^ s1_b_q;
      OP_NAND: gate_c = ~(s1_a_q & s1_b_q);
      OP_NOR:  gate_c = ~(s1_a_q | s1_b_q);
      OP_XNOR: gate_c = ~(s1_a_q ^ s1_b_q);
      default: gate_c = '0;
    endcase
  end

  // Stage 1: operand capture; a simultaneous accept and advance reloads with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 3'b000;
    end else begin
      if (in_hs_c) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= bus.a;
        s1_b_q     <= bus.b;
        s1_op_q    <= bus.op;
      end else if (s1_adv_c) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Stage 2: result register; y is left untouched when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      y_op_q     <= 3'b000;
      y_zero_q   <= 1'b0;
    end else begin
      if (s1_adv_c) begin
        s2_valid_q <= 1'b1;
        y_q        <= gate_c;
        y_op_q     <= s1_op_q;
        y_zero_q   <= ~|gate_c;
      end else if (out_hs_c) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_hs_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: table vectors, backpressure, random stream,
// counter wrap and asynchronous reset, against a truth-table/queue model.
module tb_logic_gate_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] y;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0]    y;
    logic [2:0]      op;
    logic            z;
    longint unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  logic_gate_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [CW-1:0] exp_cnt;
  logic        hold_v;
  logic [W-1:0] hold_y;
  logic [2:0]  hold_op;
  logic        hold_z;
  logic [3:0]  tt [8];
  vec_t        tab [12];
  vec_t        idle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Each gate as a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   row;
    row = tt[op];
    for (int i = 0; i < int'(W); i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic valid, input logic ordy,
                       input logic use_tab, output logic acc);
    exp_t         e;
    logic [W-1:0] ey;
    logic         ez;
    logic         exp_ov;
    @(negedge clk);
    bus.in_valid  = valid;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.op        = v.op;
    bus.out_ready = ordy;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (q[0].due <= cyc);
    check("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || ordy));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check("res_cnt", 64'(bus.res_cnt), 64'(exp_cnt));
    if (hold_v) begin
      check("hold_y", 64'(bus.y), 64'(hold_y));
      check("hold_y_op", 64'(bus.y_op), 64'(hold_op));
      check("hold_y_zero", 64'(bus.y_zero), 64'(hold_z));
    end
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat actual=%0h required=none", bus.y);
      end else begin
        e = q.pop_front();
        check("y", 64'(bus.y), 64'(e.y));
        check("y_op", 64'(bus.y_op), 64'(e.op));
        check("y_zero", 64'(bus.y_zero), 64'(e.z));
      end
      exp_cnt = exp_cnt + CW'(1);
    end
    hold_v  = bus.out_valid && !ordy;
    hold_y  = bus.y;
    hold_op = bus.y_op;
    hold_z  = bus.y_zero;
    acc = valid && bus.in_ready;
    if (acc) begin
      ey = use_tab ? v.y : ref_gate(v.op, v.a, v.b);
      ez = use_tab ? v.z : (ey == '0);
      q.push_back('{ey, v.op, ez, cyc + 2});
    end
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int i = 0; i < 6; i++) drive(idle, 1'b0, 1'b1, 1'b0, acc);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s actual=%0d beats pending required=0", name, q.size());
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v.a  = W'($urandom);
    v.b  = W'($urandom);
    v.op = 3'($urandom_range(0, 7));
    v.y  = '0;
    v.z  = 1'b0;
    return v;
  endfunction

  initial begin
    logic acc;
    vec_t cur;
    int   n;

    tt[0] = 4'b0011; tt[1] = 4'b1100; tt[2] = 4'b1000; tt[3] = 4'b1110;
    tt[4] = 4'b0110; tt[5] = 4'b0111; tt[6] = 4'b0001; tt[7] = 4'b1001;

    tab[0]  = '{8'hA5, 8'h00, 3'b000, 8'h5A, 1'b0};
    tab[1]  = '{8'hF0, 8'hCC, 3'b000, 8'h0F, 1'b0};
    tab[2]  = '{8'hF0, 8'hCC, 3'b001, 8'hF0, 1'b0};
    tab[3]  = '{8'hF0, 8'hCC, 3'b010, 8'hC0, 1'b0};
    tab[4]  = '{8'hF0, 8'hCC, 3'b011, 8'hFC, 1'b0};
    tab[5]  = '{8'hF0, 8'hCC, 3'b100, 8'h3C, 1'b0};
    tab[6]  = '{8'hF0, 8'hCC, 3'b101, 8'h3F, 1'b0};
    tab[7]  = '{8'hF0, 8'hCC, 3'b110, 8'h03, 1'b0};
    tab[8]  = '{8'hF0, 8'hCC, 3'b111, 8'hC3, 1'b0};
    tab[9]  = '{8'hFF, 8'h00, 3'b000, 8'h00, 1'b1};
    tab[10] = '{8'h3C, 8'h3C, 3'b100, 8'h00, 1'b1};
    tab[11] = '{8'h01, 8'h00, 3'b001, 8'h01, 1'b0};
    idle    = '{8'h00, 8'h00, 3'b000, 8'h00, 1'b0};

    exp_cnt = '0;
    hold_v  = 1'b0;
    hold_y  = '0;
    hold_op = 3'b000;
    hold_z  = 1'b0;

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 3'b000;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_y", 64'(bus.y), 64'(0));
    check("rst_res_cnt", 64'(bus.res_cnt), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat, then the op sweep and zero-flag vectors back to back
    drive(tab[0], 1'b1, 1'b1, 1'b1, acc);
    check("first_accept", 64'(acc), 64'(1));
    drain("single_beat");
    check("cnt_after_single", 64'(bus.res_cnt), 64'(1));
    for (int i = 1; i <= 10; i++) begin
      drive(tab[i], 1'b1, 1'b1, 1'b1, acc);
      check("sweep_accept", 64'(acc), 64'(1));
    end
    drain("op_sweep");

    // Backpressure: four beats offered against a stalled consumer
    n = 0;
    cur = rnd_vec();
    for (int c = 0; c < 30 && n < 4; c++) begin
      drive(cur, 1'b1, (c >= 6), 1'b0, acc);
      if (acc) begin
        n++;
        cur = rnd_vec();
      end
      if (c == 5) check("bp_accepted", 64'(n), 64'(2));
    end
    check("bp_all_accepted", 64'(n), 64'(4));
    drain("backpressure");

    // Random stream with random stalls
    cur = rnd_vec();
    for (int c = 0; c < 400; c++) begin
      drive(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 1'b0, acc);
      if (acc) cur = rnd_vec();
    end
    drain("random");

    // Asynchronous reset with both stages full
    n = 0;
    for (int c = 0; c < 8 && q.size() < 2; c++) begin
      drive(rnd_vec(), 1'b1, 1'b0, 1'b0, acc);
    end
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_y", 64'(bus.y), 64'(0));
    check("arst_y_op", 64'(bus.y_op), 64'(0));
    check("arst_y_zero", 64'(bus.y_zero), 64'(0));
    check("arst_res_cnt", 64'(bus.res_cnt), 64'(0));
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    q.delete();
    exp_cnt = '0;
    hold_v  = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(tab[11], 1'b1, 1'b1, 1'b1, acc);
    drain("post_reset_beat");
    check("cnt_after_arst", 64'(bus.res_cnt), 64'(1));

    // Counter wrap: 17 more completions from 1 lands on 18 mod 16
    n = 0;
    cur = rnd_vec();
    for (int c = 0; c < 60 && n < 17; c++) begin
      drive(cur, 1'b1, 1'b1, 1'b0, acc);
      if (acc) begin
        n++;
        cur = rnd_vec();
      end
    end
    drain("wrap_stream");
    check("cnt_wrap", 64'(bus.res_cnt), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
